// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out path.
// The timing values describe 640x480@60 VGA in pixel-clock units.
package fb_pkg;
  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_TOT   = 800;
  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_TOT   = 525;

  localparam int unsigned FB_W    = 160;
  localparam int unsigned FB_H    = 120;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned COLOR_W = 3;

  typedef logic [COLOR_W-1:0] color_t;
endpackage

// File: rtl/vga_timing.sv
// VGA raster counters with visible/sync decode of the current position,
// line/frame wrap strobes and a look-ahead visible flag for the next position.
module vga_timing
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       visible,
  output logic       vis_next,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       line_wrap,
  output logic       frame_wrap
);
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    line_wrap  = pix_ce && (h_cnt_q == 10'(H_TOT - 1));
    frame_wrap = line_wrap && (v_cnt_q == 10'(V_TOT - 1));
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    if (pix_ce) begin
      h_cnt_d = line_wrap ? '0 : h_cnt_q + 10'd1;
      if (line_wrap) v_cnt_d = frame_wrap ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    visible  = (h_cnt_q < 10'(H_VIS)) && (v_cnt_q < 10'(V_VIS));
    vis_next = (h_cnt_d < 10'(H_VIS)) && (v_cnt_d < 10'(V_VIS));
    hsync_n  = !((h_cnt_q >= 10'(H_VIS + H_FP)) &&
                 (h_cnt_q <  10'(H_VIS + H_FP + H_SYNC)));
    vsync_n  = !((v_cnt_q >= 10'(V_VIS + V_FP)) &&
                 (v_cnt_q <  10'(V_VIS + V_FP + V_SYNC)));
  end

  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: incremental read-address generator (stage 0) and
// registered colour/sync/de outputs one pixel slot behind the counters (stage 1).
module fb_scanout #(
  parameter int unsigned FB_W       = fb_pkg::FB_W,
  parameter int unsigned FB_H       = fb_pkg::FB_H,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned ADDR_W     = fb_pkg::ADDR_W,
  parameter int unsigned COLOR_W    = fb_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [COLOR_W-1:0] mem_do,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] rgb,
  output logic               frame_start
);
  import fb_pkg::*;

  logic [9:0] h_cnt, v_cnt;
  logic       visible, vis_next, hsync_n, vsync_n, line_wrap, frame_wrap;

  vga_timing u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .visible    (visible),
    .vis_next   (vis_next),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .line_wrap  (line_wrap),
    .frame_wrap (frame_wrap)
  );

  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic               mem_rd_q, mem_rd_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               frame_start_q, frame_start_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q    <= '0;
      row_base_q    <= '0;
      mem_rd_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      row_base_q    <= row_base_d;
      mem_rd_q      <= mem_rd_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Stage 0: the address follows the counters into their next position.
  // Lines past the last framebuffer row leave address and row base untouched.
  always_comb begin
    mem_addr_d = mem_addr_q;
    row_base_d = row_base_q;
    mem_rd_d   = mem_rd_q;
    if (pix_ce) begin
      mem_rd_d = vis_next;
      if (frame_wrap) begin
        row_base_d = '0;
        mem_addr_d = '0;
      end else if (line_wrap) begin
        if (v_cnt < 10'((FB_H << SCALE_LOG2) - 1)) begin
          if (v_cnt[SCALE_LOG2-1:0] == '1) begin
            row_base_d = row_base_q + ADDR_W'(FB_W);
            mem_addr_d = row_base_q + ADDR_W'(FB_W);
          end else begin
            mem_addr_d = row_base_q;
          end
        end
      end else if (visible && (h_cnt[SCALE_LOG2-1:0] == '1) &&
                   (h_cnt != 10'((FB_W << SCALE_LOG2) - 1))) begin
        mem_addr_d = mem_addr_q + ADDR_W'(1);
      end
    end
  end

  // Stage 1: decode of the position held before this edge, plus its colour.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    rgb_d         = rgb_q;
    frame_start_d = pix_ce && (h_cnt == '0) && (v_cnt == '0);
    if (pix_ce) begin
      hsync_d = hsync_n;
      vsync_d = vsync_n;
      de_d    = visible;
      rgb_d   = visible ? mem_do : '0;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: hand-computed vector table, closed-form raster model
// sweeps, mid-line reset and a gated (1-in-4) pixel enable run.
module tb_fb_scanout;
  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [2:0]  mem_do = '0;
  logic        hsync, vsync, de;
  logic [2:0]  rgb;
  logic        frame_start;

  fb_scanout #(
    .FB_W       (160),
    .FB_H       (120),
    .SCALE_LOG2 (2),
    .ADDR_W     (16),
    .COLOR_W    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_do      (mem_do),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Memory holds mem[a] = a % 8; data settles half a clock after the address.
  always @(negedge clk) mem_do <= mem_addr[2:0];

  int k;          // pix_ce edges since reset release
  bit last_ce;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int k;
    int addr;
    bit rd;
    bit de;
    bit hs;
    bit vs;
    int rgb;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
  endtask

  task automatic step(input bit ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
    last_ce = ce;
    if (ce) k++;
  endtask

  task automatic check_model();
    int hc, vc, ho, vo;
    int e_addr, e_rgb;
    bit e_rd, e_de, e_hs, e_vs, e_fs;
    if (k == 0) begin
      e_addr = 0; e_rd = 0; e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 0; e_fs = 0;
    end else begin
      hc = k % 800;
      vc = (k / 800) % 525;
      e_addr = (vc < 480) ? (vc / 4) * 160 + ((hc < 640) ? hc / 4 : 159) : 19199;
      e_rd = (hc < 640) && (vc < 480);
      ho = (k - 1) % 800;
      vo = ((k - 1) / 800) % 525;
      e_de = (ho < 640) && (vo < 480);
      e_hs = !((ho >= 656) && (ho < 752));
      e_vs = !((vo >= 490) && (vo < 492));
      e_rgb = e_de ? (((vo / 4) * 160 + ho / 4) % 8) : 0;
      e_fs = last_ce && ((k % 420000) == 1);
    end
    chk("mem_addr", int'(mem_addr), e_addr);
    chk("mem_rd", int'(mem_rd), int'(e_rd));
    chk("de", int'(de), int'(e_de));
    chk("hsync", int'(hsync), int'(e_hs));
    chk("vsync", int'(vsync), int'(e_vs));
    chk("rgb", int'(rgb), e_rgb);
    chk("frame_start", int'(frame_start), int'(e_fs));
  endtask

  initial begin
    int rise_k, fall_k;
    bit prev_de, prev_hs;

    //           k     addr  rd de hs vs rgb
    tbl[0]  = '{1,     0,    1, 1, 1, 1, 0};
    tbl[1]  = '{4,     1,    1, 1, 1, 1, 0};
    tbl[2]  = '{5,     1,    1, 1, 1, 1, 1};
    tbl[3]  = '{637,   159,  1, 1, 1, 1, 7};
    tbl[4]  = '{640,   159,  0, 1, 1, 1, 7};
    tbl[5]  = '{641,   159,  0, 0, 1, 1, 0};
    tbl[6]  = '{656,   159,  0, 0, 1, 1, 0};
    tbl[7]  = '{657,   159,  0, 0, 0, 1, 0};
    tbl[8]  = '{752,   159,  0, 0, 0, 1, 0};
    tbl[9]  = '{753,   159,  0, 0, 1, 1, 0};
    tbl[10] = '{800,   0,    1, 0, 1, 1, 0};
    tbl[11] = '{1605,  1,    1, 1, 1, 1, 1};
    tbl[12] = '{3200,  160,  1, 0, 1, 1, 0};
    tbl[13] = '{3205,  161,  1, 1, 1, 1, 1};
    tbl[14] = '{3840,  319,  0, 1, 1, 1, 7};

    rst = 1'b1;
    pix_ce = 1'b0;
    k = 0;
    last_ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_model();
    rst = 1'b0;
    step(1'b0);
    check_model();
    step(1'b0);
    check_model();

    for (int i = 0; i < 15; i++) begin
      while (k < tbl[i].k) step(1'b1);
      chk("tbl_addr", int'(mem_addr), tbl[i].addr);
      chk("tbl_rd", int'(mem_rd), int'(tbl[i].rd));
      chk("tbl_de", int'(de), int'(tbl[i].de));
      chk("tbl_hsync", int'(hsync), int'(tbl[i].hs));
      chk("tbl_vsync", int'(vsync), int'(tbl[i].vs));
      chk("tbl_rgb", int'(rgb), tbl[i].rgb);
    end

    // Continuous sweep through line 7 with hsync placement/width measured.
    rise_k = -1;
    fall_k = -1;
    prev_de = de;
    prev_hs = hsync;
    while (k < 6600) begin
      step(1'b1);
      check_model();
      if (de && !prev_de) rise_k = k;
      if (!hsync && prev_hs) begin
        if (rise_k >= 0) chk("hsync_start", k - rise_k, 656);
        fall_k = k;
      end
      if (hsync && !prev_hs && fall_k >= 0) chk("hsync_width", k - fall_k, 96);
      prev_de = de;
      prev_hs = hsync;
    end

    // Reset mid-line with pix_ce high: takes effect without a clock edge.
    pix_ce = 1'b1;
    rst = 1'b1;
    #1;
    k = 0;
    last_ce = 1'b0;
    check_model();
    @(posedge clk);
    #1;
    check_model();
    rst = 1'b0;
    step(1'b1);
    chk("restart_fs", int'(frame_start), 1);
    check_model();
    step(1'b1);
    check_model();

    // Gated enable: same per-pix_ce sequence, everything holds in between.
    for (int c = 0; c < 16000; c++) begin
      step((c % 4) == 0);
      check_model();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
